// File: rtl/irq_pkg.sv
// Shared types and constants for the PCIe MSI interrupt arbiter.
package irq_pkg;

  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned VEC_W   = 8;
  localparam int unsigned HOLD_W  = 16;

  localparam int unsigned SRC_TX = 0;
  localparam int unsigned SRC_RX = 1;

  localparam logic [VEC_W-1:0] TX_VECTOR_DEF = 8'h01;
  localparam logic [VEC_W-1:0] RX_VECTOR_DEF = 8'h00;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    REQ  = 3'b010,
    HOLD = 3'b100
  } state_e;

endpackage

// File: rtl/irq_edge_pending.sv
// Per-source request capture: registers send_irq, detects its rising edge
// and keeps a pending flag with set / accept-clear / withdraw handling.
module irq_edge_pending
  import irq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic send_irq,
  input  logic granted,
  input  logic clr,
  output logic pending
);

  logic level_q, level_d;
  logic pending_q, pending_d;

  // Withdraw only applies while not owning the endpoint; a rise wins over any clear.
  always_comb begin
    level_d   = send_irq;
    pending_d = pending_q;
    if (clr) begin
      pending_d = 1'b0;
    end
    if (pending_q && !send_irq && !granted) begin
      pending_d = 1'b0;
    end
    if (send_irq && !level_q) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/irq_arbiter.sv
// Round-robin sharing of the endpoint MSI request path between tx and rx.
// IRQ_ARBITER_MODERATION_EN: enforce HOLDOFF_CYCLES idle cycles between MSIs.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter logic [VEC_W-1:0] TX_VECTOR      = TX_VECTOR_DEF,
  parameter logic [VEC_W-1:0] RX_VECTOR      = RX_VECTOR_DEF,
  parameter int unsigned      HOLDOFF_CYCLES = 250
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_send_irq,
  input  logic             rx_send_irq,
  input  logic             cfg_interrupt_msienable,
  output logic             cfg_interrupt,
  input  logic             cfg_interrupt_rdy,
  output logic [VEC_W-1:0] cfg_interrupt_di,
  output logic             tx_irq_sent,
  output logic             rx_irq_sent
);

  if (HOLDOFF_CYCLES == 0 || HOLDOFF_CYCLES > (1 << HOLD_W) - 1) begin : g_bad_holdoff
    $error("irq_arbiter: HOLDOFF_CYCLES out of range");
  end

  state_e             state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic               cfg_int_q, cfg_int_d;
  logic [VEC_W-1:0]   di_q, di_d;
  logic [NUM_SRC-1:0] sent_q, sent_d;
  logic [NUM_SRC-1:0] send_irq, pending, granted_c, clr_c;
  logic               sel;
`ifdef IRQ_ARBITER_MODERATION_EN
  logic [HOLD_W-1:0]  cnt_q, cnt_d;
`endif

  assign send_irq[SRC_TX] = tx_send_irq;
  assign send_irq[SRC_RX] = rx_send_irq;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    irq_edge_pending u_edge (
      .clk      (clk),
      .rst      (rst),
      .send_irq (send_irq[i]),
      .granted  (granted_c[i]),
      .clr      (clr_c[i]),
      .pending  (pending[i])
    );
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cfg_int_d    = cfg_int_q;
    di_d         = di_q;
    sent_d       = '0;
    clr_c        = '0;
    granted_c    = '0;
    sel          = pending[SRC_RX];
`ifdef IRQ_ARBITER_MODERATION_EN
    cnt_d        = cnt_q;
`endif
    if (pending == 2'b11) begin
      sel = ~last_grant_q;
    end
    if (state_q == REQ) begin
      granted_c[grant_q] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cfg_interrupt_msienable && (|pending)) begin
          grant_d      = sel;
          last_grant_d = sel;
          cfg_int_d    = 1'b1;
          di_d         = (sel == 1'(SRC_RX)) ? RX_VECTOR : TX_VECTOR;
          state_d      = REQ;
        end
      end
      REQ: begin
        // Held until the endpoint accepts; msienable/withdraw cannot abort it.
        if (cfg_interrupt_rdy) begin
          cfg_int_d       = 1'b0;
          di_d            = '0;
          clr_c[grant_q]  = 1'b1;
          sent_d[grant_q] = 1'b1;
          state_d         = HOLD;
`ifdef IRQ_ARBITER_MODERATION_EN
          cnt_d           = HOLD_W'(HOLDOFF_CYCLES - 1);
`endif
        end
      end
      HOLD: begin
`ifdef IRQ_ARBITER_MODERATION_EN
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'(SRC_TX);
      last_grant_q <= 1'(SRC_RX);
      cfg_int_q    <= 1'b0;
      di_q         <= '0;
      sent_q       <= '0;
`ifdef IRQ_ARBITER_MODERATION_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cfg_int_q    <= cfg_int_d;
      di_q         <= di_d;
      sent_q       <= sent_d;
`ifdef IRQ_ARBITER_MODERATION_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign cfg_interrupt    = cfg_int_q;
  assign cfg_interrupt_di = di_q;
  assign tx_irq_sent      = sent_q[SRC_TX];
  assign rx_irq_sent      = sent_q[SRC_RX];

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter: stimulus queues expected MSI starts and
// sent pulses; a negedge monitor pops and compares as the DUT produces them.
module tb_irq_arbiter;

`ifdef IRQ_ARBITER_MODERATION_EN
  localparam int HG = 8;
`else
  localparam int HG = 1;
`endif
  localparam int K_REQ  = 0;
  localparam int K_SENT = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx = 1'b0, rx = 1'b0, msien = 1'b0, rdy = 1'b0;
  logic       ci, txs, rxs;
  logic [7:0] di;

  irq_arbiter #(.TX_VECTOR(8'h01), .RX_VECTOR(8'h00), .HOLDOFF_CYCLES(8)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .tx_send_irq             (tx),
    .rx_send_irq             (rx),
    .cfg_interrupt_msienable (msien),
    .cfg_interrupt           (ci),
    .cfg_interrupt_rdy       (rdy),
    .cfg_interrupt_di        (di),
    .tx_irq_sent             (txs),
    .rx_irq_sent             (rxs)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int val; int cyc; } ev_t;
  ev_t exp_q[$];

  int cyc = 0;
  int base = 0;
  int n_chk = 0;
  int n_pass = 0;
  int rdy_delay = 3;
  int hi_cnt = 0;
  logic stray_rdy = 1'b0;
  logic prev_ci = 1'b0;
  logic [7:0] di_start = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc - base);
  endtask

  function automatic void push(input int kind, input int val, input int c);
    exp_q.push_back('{kind, val, (c < 0) ? -1 : base + c});
  endfunction

  task automatic got(input int kind, input int val);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind %0d val %0d at cycle %0d, expected none",
               kind, val, cyc - base);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.val == val && (e.cyc < 0 || e.cyc == cyc)) n_pass++;
      else $display("FAIL event: got kind %0d val %0d cycle %0d, expected kind %0d val %0d cycle %0d",
                    kind, val, cyc - base, e.kind, e.val, (e.cyc < 0) ? -1 : e.cyc - base);
    end
  endtask

  // Endpoint model: accept rdy_delay cycles after cfg_interrupt rises.
  always @(negedge clk) begin
    if (ci === 1'b1) begin
      rdy = (hi_cnt == rdy_delay) || stray_rdy;
      hi_cnt++;
    end else begin
      rdy = stray_rdy;
      hi_cnt = 0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (ci === 1'b1 && prev_ci !== 1'b1) begin
      got(K_REQ, int'(di));
      di_start = di;
    end else if (ci === 1'b1) begin
      chk("di_stable", int'(di), int'(di_start));
    end
    if (txs === 1'b1 && rxs === 1'b1) chk("dual_sent", 1, 0);
    else if (txs === 1'b1) got(K_SENT, 0);
    else if (rxs === 1'b1) got(K_SENT, 1);
    prev_ci = ci;
  end

  task automatic wait_until(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  task automatic do_reset;
    tx = 1'b0; rx = 1'b0; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cfg_interrupt", int'(ci), 0);
    chk("rst_di", int'(di), 0);
    chk("rst_tx_sent", int'(txs), 0);
    chk("rst_rx_sent", int'(rxs), 0);
    rst = 1'b0;
    base = cyc;
  endtask

  initial begin
    @(negedge clk);

    // Single tx request, rdy three cycles after request
    msien = 1'b1; rdy_delay = 3;
    do_reset();
    push(K_REQ, 8'h01, 12); push(K_SENT, 0, 16);
    wait_until(10); tx = 1'b1;
    wait_until(15); chk("t1_ci_held", int'(ci), 1);
    wait_until(16); chk("t1_ci_drop", int'(ci), 0);
    wait_until(17); chk("t1_sent_once", int'(txs), 0);
    tx = 1'b0;
    wait_until(30);

    // Simultaneous rise: tx first, then rx after HOLD
    do_reset();
    push(K_REQ, 8'h01, 12); push(K_SENT, 0, 16);
    push(K_REQ, 8'h00, 17 + HG); push(K_SENT, 1, 21 + HG);
    wait_until(10); tx = 1'b1; rx = 1'b1;
    wait_until(30 + HG); tx = 1'b0; rx = 1'b0;
    wait_until(40 + HG);

    // Round-robin with both sources re-requesting
    do_reset();
    for (int m = 0; m < 2; m++) begin
      push(K_REQ, 8'h01, -1); push(K_SENT, 0, -1);
      push(K_REQ, 8'h00, -1); push(K_SENT, 1, -1);
    end
    wait_until(10); tx = 1'b1; rx = 1'b1;
    for (int m = 0; m < 4; m++) begin
      int w;
      logic src;
      w = 0;
      while (!(txs === 1'b1 || rxs === 1'b1) && w < 400) begin
        @(negedge clk);
        w++;
      end
      if (w >= 400) chk("rr_timeout", w, 0);
      src = rxs;
      if (m < 2) begin
        if (src) rx = 1'b0; else tx = 1'b0;
        @(negedge clk);
        if (src) rx = 1'b1; else tx = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    tx = 1'b0; rx = 1'b0;
    repeat (20) @(negedge clk);

    // msienable gating plus rdy while idle
    msien = 1'b0;
    do_reset();
    push(K_REQ, 8'h00, 51); push(K_SENT, 1, 55);
    wait_until(5); rx = 1'b1;
    wait_until(20); stray_rdy = 1'b1;
    wait_until(21); stray_rdy = 1'b0;
    chk("stray_rdy_tx", int'(txs), 0);
    chk("stray_rdy_rx", int'(rxs), 0);
    wait_until(49); chk("gated_ci", int'(ci), 0);
    wait_until(50); msien = 1'b1;
    wait_until(56); rx = 1'b0;
    wait_until(65);

    // rx withdrawn while tx held in REQ with a late rdy
    rdy_delay = 20;
    do_reset();
    push(K_REQ, 8'h01, 12); push(K_SENT, 0, 33);
    wait_until(10); tx = 1'b1;
    wait_until(13); rx = 1'b1;
    wait_until(16); rx = 1'b0;
    wait_until(31); chk("late_rdy_ci_held", int'(ci), 1);
    wait_until(34); tx = 1'b0;
    wait_until(45); chk("withdrawn_no_rx", int'(ci), 0);
    chk("withdrawn_q_empty", exp_q.size(), 0);

    // Back-to-back tx with the re-rise landing in the clear cycle
    rdy_delay = 0;
    do_reset();
    push(K_REQ, 8'h01, 12); push(K_SENT, 0, 13);
    push(K_REQ, 8'h01, 14 + HG); push(K_SENT, 0, 15 + HG);
    wait_until(10); tx = 1'b1;
    wait_until(11); tx = 1'b0;
    wait_until(12); tx = 1'b1;
    wait_until(13 + HG); chk("gap_ci_low", int'(ci), 0);
    wait_until(20 + HG); tx = 1'b0;
    wait_until(30 + HG);

    // Reset in the middle of a handshake
    rdy_delay = 100;
    do_reset();
    push(K_REQ, 8'h01, 12);
    wait_until(10); tx = 1'b1;
    wait_until(14); tx = 1'b0; rst = 1'b1;
    wait_until(15); rst = 1'b0;
    chk("midrst_ci", int'(ci), 0);
    chk("midrst_sent", int'(txs), 0);
    wait_until(16); chk("midrst_sent_late", int'(txs), 0);
    wait_until(30);

    chk("final_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
